m_alu_seq: RTL and testbench
============================

Name: m_alu_seq

Overview:
- Multi-cycle sequencer that drives the shared midgetv ALU, using its op-select lines, carry-in and operand buses, to run operations the single-cycle ALU cannot do alone: SLL by N, SUB and low-word MUL.
- Sits beside the ALU. It muxes its own operands onto Di/ADR_O/QQ while busy and captures B/carry-out each cycle into internal registers.
- Intended as the execution engine for trap-emulated shift/mul sequences.

Parameters:
- ALUWIDTH, 32, datapath width; legal values 8, 16, 32 (power of two).
- CNTW, 5, shift-count width; must equal log2(ALUWIDTH).

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  synchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00=SLL, 01=SUB, 10=MUL, 11=ADD.
- opa  in  ALUWIDTH  first operand (minuend / multiplicand / value to shift).
- opb  in  ALUWIDTH  second operand; SLL uses opb[CNTW-1:0] as count.
- busy  out  1  high while the sequence runs.
- done  out  1  one-cycle pulse when result is valid.
- result  out  ALUWIDTH  registered result; held until the next accepted start.
- cy  out  1  registered carry-out of the last ADD-class ALU cycle; 0 for SLL/MUL.
- alu_sa06, alu_sa05, alu_sa04  out  1 each  ALU op select.
- alu_cin  out  1  ALU carry-in.
- alu_di, alu_adr, alu_qq  out  ALUWIDTH each  ALU operands Di, ADR_O, QQ.
- alu_b  in  ALUWIDTH  ALU result B.
- alu_cy  in  1  ALU carry-out.

Behaviour:
- ALU op codes (sa06 sa05 sa04): ADD=100 (B=Di+QQ+cin), SHLQ=101 (B=(QQ<<1)|cin, Di must be all-ones), INVQ=011 (B=~ADR_O), PASSQ=111 (B=QQ+cin), PASSD=001.
- ALU outputs are combinational from state and internal regs. ALU result is captured at the clock edge ending each ALU cycle.
- Internal regs: P (accumulator), M (multiplicand/shift value), R (multiplier, shifted right internally), C (count).
- Reset values: busy=0, done=0, result=0, cy=0, state=IDLE, P=M=R=C=0.
- Idle ALU drive: PASSD, cin=0, all operand buses 0.
- States: IDLE, SLL, SUBINV, SUBADD, ADD1, MADD, MSHL, DONE.
- IDLE: start=1 loads M=opa, R=opb, P=0, C=opb[CNTW-1:0], then branches on op:
  - SLL with C=0 -> DONE with result=opa; no ALU cycle.
  - SLL with C!=0 -> SLL.
  - SUB -> SUBINV.
  - ADD -> ADD1.
  - MUL with opb=0 -> DONE with result=0.
  - MUL with opb!=0 -> MADD if opb[0]=1, else MSHL.
- busy=1 in every state except IDLE and DONE.
- SLL: SHLQ with QQ=M, Di=all-ones, cin=0; M<=alu_b; C<=C-1. Go to DONE when C==1. This costs exactly count cycles.
- SUBINV: INVQ with ADR_O=opb (held in R); P<=alu_b.
- SUBADD: ADD with Di=M, QQ=P, cin=1; result<=alu_b, cy<=alu_cy (1 = no borrow). Next state DONE.
- ADD1: ADD with Di=M, QQ=R, cin=0; result<=alu_b, cy<=alu_cy. Next state DONE.
- MADD: ADD with Di=P, QQ=M, cin=0; P<=alu_b. Next state MSHL.
- MSHL: SHLQ with QQ=M; M<=alu_b; R<=R>>1.
  - Next state: if R>>1==0 -> DONE with result=P.
  - Else MADD if (R>>1)[0]=1, else MSHL.
- MUL cost: n+k ALU cycles, where n = MSB index of opb + 1 and k = popcount(opb). Carry out of MADD is discarded (mod 2^ALUWIDTH); cy=0.
- DONE: done=1, busy=0, result valid. Next state is always IDLE. A start asserted during DONE is ignored.
- Latency: start sampled at edge t; ALU cycles occupy t+1..t+N; done is high during cycle t+N+1; the earliest next start is accepted at the edge ending that cycle+1 (IDLE).
- start while busy: ignored, with no effect on the running operation or on opa/opb capture.
- RST_I mid-operation: next cycle is IDLE, all outputs return to reset values, and no done pulse is produced.
- Widths: all arithmetic is mod 2^ALUWIDTH. The shift count is opb mod ALUWIDTH.

Test Plan:
- Reset: RST_I=1 for 2 cycles during a MUL -> busy=0, done=0, result=0; idle ALU drive = 001 with zero operands.
- SLL: opa=0x00000001, opb=5 -> 5 SHLQ cycles (sa=101, Di=0xFFFFFFFF), done at t+6, result=0x00000020. With opb=0 -> done at t+1, result=opa.
- SUB: opa=10, opb=3 -> INVQ then ADD cin=1, result=7, cy=1. With opa=3, opb=10 -> result=0xFFFFFFF9, cy=0.
- MUL: opa=3, opb=5 -> 5 ALU cycles in sequence MADD, MSHL, MSHL, MADD, MSHL; done at t+6; result=15. With opa=0xFFFFFFFF, opb=0xFFFFFFFF -> 64 ALU cycles, result=1.
- ADD: opa=0xFFFFFFFF, opb=1 -> single ALU cycle, result=0, cy=1. Back-to-back: start held high continuously -> operations run serially, one IDLE cycle between each done and the next busy.
- Start ignored: start pulsed mid-MUL with different op/opb -> original result unchanged. At ALUWIDTH=8, SLL opb=9 -> shift by 1.

Source files
------------

// File: rtl/m_alu_seq_if.sv
// m_alu_seq_if: request/result handshake plus the ALU op-select and operand buses of m_alu_seq
interface m_alu_seq_if #(parameter int ALUWIDTH = 32);
  logic                start;
  logic [1:0]          op;
  logic [ALUWIDTH-1:0] opa;
  logic [ALUWIDTH-1:0] opb;
  logic                busy;
  logic                done;
  logic [ALUWIDTH-1:0] result;
  logic                cy;
  logic                alu_sa06;
  logic                alu_sa05;
  logic                alu_sa04;
  logic                alu_cin;
  logic [ALUWIDTH-1:0] alu_di;
  logic [ALUWIDTH-1:0] alu_adr;
  logic [ALUWIDTH-1:0] alu_qq;
  logic [ALUWIDTH-1:0] alu_b;
  logic                alu_cy;
  modport master (
    output start, op, opa, opb, alu_b, alu_cy,
    input  busy, done, result, cy, alu_sa06, alu_sa05, alu_sa04, alu_cin, alu_di, alu_adr, alu_qq
  );
  modport slave (
    input  start, op, opa, opb, alu_b, alu_cy,
    output busy, done, result, cy, alu_sa06, alu_sa05, alu_sa04, alu_cin, alu_di, alu_adr, alu_qq
  );
endinterface

// File: rtl/m_alu_seq.sv
// m_alu_seq: multi-cycle SLL/SUB/MUL/ADD sequencer driving the shared single-cycle ALU
module m_alu_seq #(
  parameter int ALUWIDTH = 32,
  parameter int CNTW     = 5
) (
  input logic         CLK_I,
  input logic         RST_I,
  m_alu_seq_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, SLL, SUBINV, SUBADD, ADD1, MADD, MSHL, DONE} state_t;
  state_t              state_q, state_d;
  logic [ALUWIDTH-1:0] p_q, p_d, m_q, m_d, r_q, r_d, result_q, result_d;
  logic [CNTW-1:0]     c_q, c_d;
  logic                cy_q, cy_d, busy_q, busy_d, done_q, done_d;
  logic [2:0]          sa;
  logic                cin;
  logic [ALUWIDTH-1:0] di, adr, qq, r_sh;
  assign r_sh = r_q >> 1;
  always_comb begin
    sa  = 3'b001;
    cin = 1'b0;
    di  = '0;
    adr = '0;
    qq  = '0;
    case (state_q)
      SLL, MSHL: begin sa = 3'b101; di = '1; qq = m_q; end
      SUBINV:    begin sa = 3'b011; adr = r_q; end
      SUBADD:    begin sa = 3'b100; di = m_q; qq = p_q; cin = 1'b1; end
      ADD1:      begin sa = 3'b100; di = m_q; qq = r_q; end
      MADD:      begin sa = 3'b100; di = p_q; qq = m_q; end
      default:   ;
    endcase
  end
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    m_d      = m_q;
    r_d      = r_q;
    c_d      = c_q;
    result_d = result_q;
    cy_d     = cy_q;
    case (state_q)
      IDLE: if (bus.start) begin
        m_d  = bus.opa;
        r_d  = bus.opb;
        p_d  = '0;
        c_d  = bus.opb[CNTW-1:0];
        cy_d = bus.op[0] ? cy_q : 1'b0;
        case (bus.op)
          2'b00: begin
            state_d  = (c_d == '0) ? DONE : SLL;
            result_d = (c_d == '0) ? bus.opa : result_q;
          end
          2'b01: state_d = SUBINV;
          2'b11: state_d = ADD1;
          default: begin
            state_d  = (bus.opb == '0) ? DONE : (bus.opb[0] ? MADD : MSHL);
            result_d = (bus.opb == '0) ? '0 : result_q;
          end
        endcase
      end
      SLL: begin
        m_d      = bus.alu_b;
        c_d      = c_q - CNTW'(1);
        state_d  = (c_q == CNTW'(1)) ? DONE : SLL;
        result_d = (c_q == CNTW'(1)) ? bus.alu_b : result_q;
      end
      SUBINV: begin
        p_d     = bus.alu_b;
        state_d = SUBADD;
      end
      SUBADD, ADD1: begin
        result_d = bus.alu_b;
        cy_d     = bus.alu_cy;
        state_d  = DONE;
      end
      MADD: begin
        p_d     = bus.alu_b;
        state_d = MSHL;
      end
      MSHL: begin
        m_d      = bus.alu_b;
        r_d      = r_sh;
        state_d  = (r_sh == '0) ? DONE : (r_sh[0] ? MADD : MSHL);
        result_d = (r_sh == '0) ? p_q : result_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= IDLE;
      p_q      <= '0;
      m_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      result_q <= '0;
      cy_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      m_q      <= m_d;
      r_q      <= r_d;
      c_q      <= c_d;
      result_q <= result_d;
      cy_q     <= cy_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.cy      = cy_q;
  assign {bus.alu_sa06, bus.alu_sa05, bus.alu_sa04} = sa;
  assign bus.alu_cin = cin;
  assign bus.alu_di  = di;
  assign bus.alu_adr = adr;
  assign bus.alu_qq  = qq;
endmodule

// File: tb/tb_m_alu_seq.sv
// tb_m_alu_seq: directed vectors against a cycle-level behavioural model of m_alu_seq
module tb_m_alu_seq;
  logic CLK_I = 1'b0;
  logic RST_I = 1'b1;
  always #5 CLK_I = ~CLK_I;
  m_alu_seq_if #(.ALUWIDTH(32)) bus();
  m_alu_seq_if #(.ALUWIDTH(8))  bus8();
  m_alu_seq #(.ALUWIDTH(32), .CNTW(5)) dut  (.CLK_I(CLK_I), .RST_I(RST_I), .bus(bus));
  m_alu_seq #(.ALUWIDTH(8),  .CNTW(3)) dut8 (.CLK_I(CLK_I), .RST_I(RST_I), .bus(bus8));
  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic [2:0] trace[$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [32:0] alu(input logic [2:0] s_a, input logic c_in, input logic [31:0] d_i, a_d, q_q, input int w);
    logic [32:0] s;
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case (s_a)
      3'b100:  s = {1'b0, d_i & mask} + {1'b0, q_q & mask} + {32'd0, c_in};
      3'b101:  s = {1'b0, (q_q << 1) | {31'd0, c_in}};
      3'b011:  s = {1'b0, ~a_d};
      3'b111:  s = {1'b0, q_q & mask} + {32'd0, c_in};
      3'b001:  s = {1'b0, d_i};
      default: s = '0;
    endcase
    return {s[w], s[31:0] & mask};
  endfunction
  logic [2:0]  sa, sa8;
  logic [32:0] r8;
  assign sa  = {bus.alu_sa06, bus.alu_sa05, bus.alu_sa04};
  assign sa8 = {bus8.alu_sa06, bus8.alu_sa05, bus8.alu_sa04};
  assign {bus.alu_cy, bus.alu_b} = alu(sa, bus.alu_cin, bus.alu_di, bus.alu_adr, bus.alu_qq, 32);
  assign r8 = alu(sa8, bus8.alu_cin, {24'd0, bus8.alu_di}, {24'd0, bus8.alu_adr}, {24'd0, bus8.alu_qq}, 8);
  assign bus8.alu_b  = r8[7:0];
  assign bus8.alu_cy = r8[32];
  typedef struct packed {logic [31:0] res; logic c; logic [7:0] n;} exp_t;
  function automatic exp_t model_fn(input logic [1:0] op, input logic [31:0] a, b);
    exp_t e;
    logic [32:0] s;
    int msb;
    e = '0;
    case (op)
      2'b00: begin e.n = 8'(b % 32); e.res = a << (b % 32); end
      2'b01: begin e.res = a - b; e.c = (a >= b); e.n = 8'd2; end
      2'b11: begin s = {1'b0, a} + {1'b0, b}; e.res = s[31:0]; e.c = s[32]; e.n = 8'd1; end
      default: begin
        msb = 0;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i + 1;
        e.res = a * b;
        e.n = 8'(msb + $countones(b));
      end
    endcase
    return e;
  endfunction
  exp_t req_e, pend;
  int mph = 0;
  int rem = 0;
  logic [31:0] exp_result = '0;
  logic exp_cy = 1'b0;
  assign req_e = model_fn(bus.op, bus.opa, bus.opb);
  always @(posedge CLK_I) begin
    if (RST_I) begin
      mph <= 0;
      exp_result <= '0;
      exp_cy <= 1'b0;
    end else case (mph)
      0: if (bus.start) begin
        pend <= req_e;
        rem <= int'(req_e.n);
        if (req_e.n == 8'd0) begin mph <= 2; exp_result <= req_e.res; exp_cy <= req_e.c; end
        else mph <= 1;
      end
      1: begin
        rem <= rem - 1;
        if (rem == 1) begin mph <= 2; exp_result <= pend.res; exp_cy <= pend.c; end
      end
      default: mph <= 0;
    endcase
  end
  always @(negedge CLK_I) if (chk_en) begin
    chk("busy", 64'(bus.busy), 64'(mph == 1));
    chk("done", 64'(bus.done), 64'(mph == 2));
    chk("result", 64'(bus.result), 64'(exp_result));
    if (mph == 2) chk("cy", 64'(bus.cy), 64'(exp_cy));
    if (mph != 1) chk("idle_drive", 64'({sa, bus.alu_cin, |{bus.alu_di, bus.alu_adr, bus.alu_qq}}), 64'(5'b00100));
    if (sa == 3'b101) chk("shlq_di", 64'(bus.alu_di), 64'(32'hFFFF_FFFF));
    if (bus.busy) trace.push_back(sa);
  end
  task automatic run(input logic [1:0] op, input logic [31:0] a, b, input logic [31:0] xres,
                     input logic xcy, input int xn, input int glitch, input string nm);
    int k;
    @(negedge CLK_I);
    bus.start = 1'b1; bus.op = op; bus.opa = a; bus.opb = b;
    trace.delete();
    @(negedge CLK_I);
    bus.start = 1'b0;
    k = 1;
    while (!bus.done && k < 200) begin
      @(negedge CLK_I);
      k++;
      bus.start = (k == glitch);
      if (k == glitch) begin bus.op = 2'b01; bus.opa = 32'd7; bus.opb = 32'd99; end
    end
    bus.start = 1'b0;
    chk({nm, "_lat"}, 64'(k), 64'(xn + 1));
    chk({nm, "_res"}, 64'(bus.result), 64'(xres));
    chk({nm, "_cy"}, 64'(bus.cy), 64'(xcy));
    chk({nm, "_model"}, 64'(exp_result), 64'(xres));
    chk({nm, "_alucycles"}, 64'(trace.size()), 64'(xn));
  endtask
  task automatic run8(input logic [1:0] op, input logic [7:0] a, b, input logic [7:0] xres, input int xn, input string nm);
    int k;
    @(negedge CLK_I);
    bus8.start = 1'b1; bus8.op = op; bus8.opa = a; bus8.opb = b;
    @(negedge CLK_I);
    bus8.start = 1'b0;
    k = 1;
    while (!bus8.done && k < 100) begin @(negedge CLK_I); k++; end
    chk({nm, "_lat"}, 64'(k), 64'(xn + 1));
    chk({nm, "_res"}, 64'(bus8.result), 64'(xres));
  endtask
  logic [14:0] seq;
  int dk[3];
  int k, nd;
  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.opa = '0; bus.opb = '0;
    bus8.start = 1'b0; bus8.op = 2'b00; bus8.opa = '0; bus8.opb = '0;
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    run(2'b00, 32'h1, 32'd5, 32'h20, 1'b0, 5, 0, "sll5");
    run(2'b00, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1'b0, 0, 0, "sll0");
    run(2'b00, 32'h1234_5678, 32'd36, 32'h2345_6780, 1'b0, 4, 0, "sll36");
    run(2'b01, 32'd10, 32'd3, 32'd7, 1'b1, 2, 0, "sub");
    run(2'b00, 32'd3, 32'd1, 32'd6, 1'b0, 1, 0, "sll1");
    run(2'b01, 32'd3, 32'd10, 32'hFFFF_FFF9, 1'b0, 2, 0, "subneg");
    run(2'b10, 32'd3, 32'd5, 32'd15, 1'b0, 5, 0, "mul35");
    seq = '0;
    foreach (trace[i]) if (i < 5) seq[14-3*i -: 3] = trace[i];
    chk("mul35_seq", 64'(seq), 64'(15'b100_101_101_100_101));
    run(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 64, 0, "mulff");
    run(2'b10, 32'd1234, 32'd0, 32'd0, 1'b0, 0, 0, "mul0");
    run(2'b11, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1, 0, "addwrap");
    run(2'b11, 32'd100, 32'd23, 32'd123, 1'b0, 1, 0, "add");
    run(2'b10, 32'd3, 32'd5, 32'd15, 1'b0, 5, 2, "mul_ignore");
    @(negedge CLK_I);
    bus.start = 1'b1; bus.op = 2'b11; bus.opa = 32'd5; bus.opb = 32'd6;
    k = 0; nd = 0;
    while (nd < 3 && k < 50) begin
      @(negedge CLK_I);
      k++;
      if (bus.done) begin dk[nd] = k; nd++; end
    end
    bus.start = 1'b0;
    chk("b2b_d0", 64'(dk[0]), 64'd2);
    chk("b2b_d1", 64'(dk[1]), 64'd5);
    chk("b2b_d2", 64'(dk[2]), 64'd8);
    chk("b2b_res", 64'(bus.result), 64'd11);
    @(negedge CLK_I);
    bus.start = 1'b1; bus.op = 2'b10; bus.opa = 32'hFFFF_FFFF; bus.opb = 32'hFFFF_FFFF;
    @(negedge CLK_I);
    bus.start = 1'b0;
    repeat (4) @(negedge CLK_I);
    RST_I = 1'b1;
    repeat (2) @(negedge CLK_I);
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_done", 64'(bus.done), 64'd0);
    chk("mrst_result", 64'(bus.result), 64'd0);
    chk("mrst_sa", 64'(sa), 64'(3'b001));
    chk("mrst_ops", 64'({bus.alu_di, bus.alu_qq}), 64'd0);
    RST_I = 1'b0;
    repeat (3) @(negedge CLK_I);
    run(2'b11, 32'd1, 32'd2, 32'd3, 1'b0, 1, 0, "post_rst");
    run8(2'b00, 8'h03, 8'd9, 8'h06, 1, "w8_sll9");
    run8(2'b10, 8'h10, 8'h11, 8'h10, 7, "w8_mul");
    repeat (2) @(negedge CLK_I);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
